// File: rtl/veerwolf_gpio_pack_if.sv
// veerwolf_gpio_pack_if -- single-cycle register port between the bus adapter
// (master) and the GPIO controller (slave).
//   i_wr_en  write strobe
//   i_addr   register address, shared by read and write
//   i_wdata  write data
//   i_rd_en  read strobe
//   o_rdata  read data, valid the cycle after i_rd_en
interface veerwolf_gpio_pack_if;
    logic        i_wr_en;
    logic [1:0]  i_addr;
    logic [31:0] i_wdata;
    logic        i_rd_en;
    logic [31:0] o_rdata;

    modport master (output i_wr_en, i_addr, i_wdata, i_rd_en, input o_rdata);
    modport slave  (input i_wr_en, i_addr, i_wdata, i_rd_en, output o_rdata);
endinterface

// File: rtl/veerwolf_gpio_pack.sv
// veerwolf_gpio_pack -- switch/LED controller for Wolf Pack style boards.
// Synchronises and debounces switches, flags debounced changes as pulses and
// sticky status, drives LEDs from a register with per-LED blink.
// Optional edge interrupt enabled by defining VEERWOLF_GPIO_IRQ_EN.
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   i_sw        raw switch pins (asynchronous)
//   o_sw_db     debounced switch state
//   o_sw_edge   one-cycle pulse per accepted change
//   o_led       LED drive
//   o_irq       level interrupt (0 unless VEERWOLF_GPIO_IRQ_EN)
//   bus         register port: 0 LED value, 1 blink mask, 2 switch state,
//               3 edge status (write-1-to-clear)
module veerwolf_gpio_pack #(
    parameter int unsigned NUM_SW      = 16,
    parameter int unsigned NUM_LED     = 16,
    parameter int unsigned DEB_CYCLES  = 1000,
    parameter int unsigned BLINK_DIV_W = 24
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NUM_SW-1:0]   i_sw,
    output logic [NUM_SW-1:0]   o_sw_db,
    output logic [NUM_SW-1:0]   o_sw_edge,
    output logic [NUM_LED-1:0]  o_led,
    output logic                o_irq,
    veerwolf_gpio_pack_if.slave bus
);
    localparam int unsigned     CntW   = $clog2(DEB_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

    logic [NUM_SW-1:0]            sync1_q, sync2_q;
    logic [NUM_SW-1:0]            stable_q, stable_d;
    logic [NUM_SW-1:0][CntW-1:0]  cnt_q, cnt_d;
    logic [NUM_SW-1:0]            edge_q, edge_d;
    logic [NUM_SW-1:0]            status_q, status_d;
    logic [NUM_LED-1:0]           led_val_q, led_val_d;
    logic [NUM_LED-1:0]           blink_q, blink_d;
    logic [NUM_LED-1:0]           led_q, led_d;
    logic [BLINK_DIV_W-1:0]       div_q, div_d;
    logic [31:0]                  rdata_q, rd_val;
    logic                         wr0, wr1, wr3, w1c_en;

    assign wr0 = bus.i_wr_en && (bus.i_addr == 2'd0);
    assign wr1 = bus.i_wr_en && (bus.i_addr == 2'd1);
    assign wr3 = bus.i_wr_en && (bus.i_addr == 2'd3);

`ifdef VEERWOLF_GPIO_IRQ_EN
    logic [NUM_SW-1:0] irq_en_q, irq_en_d;
    logic              irq_q;

    // With wide LED banks the enable mask moves to address 3, selected by bit 31.
    assign w1c_en = wr3 && !((NUM_LED > 16) && bus.i_wdata[31]);

    always_comb begin
        irq_en_d = irq_en_q;
        if (NUM_LED <= 16) begin
            if (wr1) irq_en_d = NUM_SW'(bus.i_wdata[31:16]);
        end else if (wr3 && bus.i_wdata[31]) begin
            irq_en_d = bus.i_wdata[NUM_SW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= |(status_q & irq_en_q);
        end
    end

    assign o_irq = irq_q;
`else
    assign w1c_en = wr3;
    assign o_irq  = 1'b0;
`endif

    // Debounce: count while sync differs from stable; any return to stable restarts.
    always_comb begin
        stable_d = stable_q;
        edge_d   = '0;
        for (int i = 0; i < int'(NUM_SW); i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    stable_d[i] = sync2_q[i];
                    edge_d[i]   = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    // A new edge wins over a same-cycle clear of the same bit.
    always_comb begin
        status_d = status_q;
        if (w1c_en) status_d = status_d & ~bus.i_wdata[NUM_SW-1:0];
        status_d = status_d | edge_d;
    end

    // LED output tracks next-state registers so a write shows one cycle later.
    always_comb begin
        led_val_d = wr0 ? bus.i_wdata[NUM_LED-1:0] : led_val_q;
        blink_d   = wr1 ? bus.i_wdata[NUM_LED-1:0] : blink_q;
        div_d     = div_q + BLINK_DIV_W'(1);
        led_d     = led_val_d & (~blink_d | {NUM_LED{div_d[BLINK_DIV_W-1]}});
    end

    // Reads see pre-write register contents.
    always_comb begin
        rd_val = '0;
        unique case (bus.i_addr)
            2'd0: rd_val = 32'(led_val_q);
            2'd1: begin
                rd_val = 32'(blink_q);
`ifdef VEERWOLF_GPIO_IRQ_EN
                if (NUM_LED <= 16) rd_val[31:16] = 16'(irq_en_q);
`endif
            end
            2'd2: rd_val = 32'(stable_q);
            2'd3: rd_val = 32'(status_q);
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            cnt_q     <= '0;
            edge_q    <= '0;
            status_q  <= '0;
            led_val_q <= '0;
            blink_q   <= '0;
            led_q     <= '0;
            div_q     <= '0;
            rdata_q   <= '0;
        end else begin
            sync1_q   <= i_sw;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            edge_q    <= edge_d;
            status_q  <= status_d;
            led_val_q <= led_val_d;
            blink_q   <= blink_d;
            led_q     <= led_d;
            div_q     <= div_d;
            if (bus.i_rd_en) rdata_q <= rd_val;
        end
    end

    assign o_sw_db     = stable_q;
    assign o_sw_edge   = edge_q;
    assign o_led       = led_q;
    assign bus.o_rdata = rdata_q;
endmodule

// File: tb/tb_veerwolf_gpio_pack.sv
// tb_veerwolf_gpio_pack -- directed bench for veerwolf_gpio_pack with
// DEB_CYCLES=4 and BLINK_DIV_W=4. Interrupt checks follow VEERWOLF_GPIO_IRQ_EN.
module tb_veerwolf_gpio_pack;
    localparam int unsigned Deb = 4;
`ifdef VEERWOLF_GPIO_IRQ_EN
    localparam bit IrqOn = 1'b1;
`else
    localparam bit IrqOn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] sw = '0;
    logic [15:0] sw_db, sw_edge, led;
    logic        irq;
    int          n_checks = 0;
    int          n_fail = 0;

    veerwolf_gpio_pack_if bus ();

    veerwolf_gpio_pack #(
        .NUM_SW      (16),
        .NUM_LED     (16),
        .DEB_CYCLES  (Deb),
        .BLINK_DIV_W (4)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .i_sw      (sw),
        .o_sw_db   (sw_db),
        .o_sw_edge (sw_edge),
        .o_led     (led),
        .o_irq     (irq),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Bus helpers start and end at a falling edge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.i_wr_en = 1'b1; bus.i_addr = a; bus.i_wdata = d;
        @(posedge clk); @(negedge clk);
        bus.i_wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus.i_rd_en = 1'b1; bus.i_addr = a;
        @(posedge clk); @(negedge clk);
        bus.i_rd_en = 1'b0;
        d = bus.o_rdata;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        #12;
        n_checks++;
        if ({led, sw_db, sw_edge, irq} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got led=%h db=%h edge=%h irq=%b required all 0",
                     led, sw_db, sw_edge, irq);
        end
        n_checks++;
        if (bus.o_rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata: got %h required 0", bus.o_rdata);
        end
        @(negedge clk); rstn = 1'b1;
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), rd);
            n_checks++;
            if (rd !== 32'h0) begin
                n_fail++; $display("FAIL reset_reg%0d: got %h required 0", a, rd);
            end
        end
    endtask

    // Clean 0->1 on channel 0: accepted on the 6th edge after first sample.
    task automatic test_debounce_accept();
        logic [31:0] rd;
        sw[0] = 1'b1;
        for (int k = 1; k <= Deb + 3; k++) begin
            @(posedge clk); @(negedge clk);
            n_checks++;
            if (sw_db[0] !== (k >= int'(Deb) + 2)) begin
                n_fail++; $display("FAIL accept_db k=%0d: got %b required %b", k, sw_db[0],
                                   k >= int'(Deb) + 2);
            end
            n_checks++;
            if (sw_edge !== ((k == int'(Deb) + 2) ? 16'h1 : 16'h0)) begin
                n_fail++; $display("FAIL accept_edge k=%0d: got %h", k, sw_edge);
            end
        end
        bus_read(2'd3, rd);
        n_checks++;
        if (rd !== 32'h1) begin n_fail++; $display("FAIL accept_status: got %h required 1", rd); end
        bus_read(2'd2, rd);
        n_checks++;
        if (rd !== 32'h1) begin n_fail++; $display("FAIL accept_swreg: got %h required 1", rd); end
    endtask

    // Channel 3 high for only DEB_CYCLES-1 synchronised cycles: never accepted.
    task automatic test_bounce();
        logic [31:0] rd;
        sw[3] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); @(negedge clk);
            if (k == 3) sw[3] = 1'b0;
            n_checks++;
            if (sw_db[3] !== 1'b0 || sw_edge[3] !== 1'b0) begin
                n_fail++; $display("FAIL bounce k=%0d: got db=%b edge=%b required 0 0", k,
                                   sw_db[3], sw_edge[3]);
            end
        end
        bus_read(2'd3, rd);
        n_checks++;
        if (rd !== 32'h1) begin n_fail++; $display("FAIL bounce_status: got %h required 1", rd); end
    endtask

    task automatic test_leds();
        logic [31:0] rd;
        logic        prev, cur, first, exp;
        int          t0;
        bus_write(2'd1, 32'h0);
        bus_write(2'd0, 32'h0000_003C);
        n_checks++;
        if (led !== 16'h003C) begin n_fail++; $display("FAIL led_write: got %h required 003c", led); end
        // Simultaneous read and write of address 0 returns the old value.
        bus.i_wr_en = 1'b1; bus.i_wdata = 32'hFFFF_00A5;
        bus_read(2'd0, rd);
        bus.i_wr_en = 1'b0;
        n_checks++;
        if (rd !== 32'h3C) begin n_fail++; $display("FAIL rd_wr_same: got %h required 3c", rd); end
        n_checks++;
        if (led !== 16'h00A5) begin n_fail++; $display("FAIL led_a5: got %h required 00a5", led); end
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (bus.o_rdata !== 32'h3C) begin
            n_fail++; $display("FAIL rdata_hold: got %h required 3c", bus.o_rdata);
        end
        bus_read(2'd0, rd);
        n_checks++;
        if (rd !== 32'hA5) begin n_fail++; $display("FAIL led_upper_ignored: got %h required a5", rd); end
        bus_write(2'd2, 32'hFFFF);
        bus_read(2'd2, rd);
        n_checks++;
        if (rd !== 32'h1) begin n_fail++; $display("FAIL swreg_ro: got %h required 1", rd); end
        // Blink bit 0 with a 4-bit divider: half period of 8 cycles.
        bus_write(2'd1, 32'h1);
        bus_read(2'd1, rd);
        n_checks++;
`ifdef VEERWOLF_GPIO_IRQ_EN
        if (rd !== 32'h1) begin n_fail++; $display("FAIL mask_read: got %h required 1", rd); end
`else
        if (rd !== 32'h1) begin n_fail++; $display("FAIL mask_read: got %h required 1", rd); end
`endif
        t0 = -1; first = 1'b0; prev = led[0];
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); @(negedge clk);
            cur = led[0];
            n_checks++;
            if (led[15:1] !== 15'h0052) begin
                n_fail++; $display("FAIL blink_steady n=%0d: got %h required 0052", n, led[15:1]);
            end
            if (t0 < 0) begin
                if (cur != prev) begin t0 = n; first = cur; end
            end else begin
                exp = first ^ 1'(((n - t0) / 8) % 2);
                n_checks++;
                if (cur !== exp) begin
                    n_fail++; $display("FAIL blink n=%0d: got %b required %b", n, cur, exp);
                end
            end
            prev = cur;
        end
        n_checks++;
        if (t0 < 0 || t0 > 16) begin n_fail++; $display("FAIL blink_toggle: first at %0d required 1..16", t0); end
    endtask

    // Clear of status bit 0 in the same cycle a new channel-0 edge lands.
    task automatic test_w1c_race();
        logic [31:0] rd;
        sw[0] = 1'b0;
        for (int k = 1; k < int'(Deb) + 2; k++) begin @(posedge clk); @(negedge clk); end
        bus_write(2'd3, 32'h1);
        n_checks++;
        if (sw_edge[0] !== 1'b1 || sw_db[0] !== 1'b0) begin
            n_fail++; $display("FAIL race_edge: got edge=%b db=%b required 1 0", sw_edge[0], sw_db[0]);
        end
        bus_read(2'd3, rd);
        n_checks++;
        if (rd !== 32'h1) begin n_fail++; $display("FAIL race_set_wins: got %h required 1", rd); end
        bus_write(2'd3, 32'h1);
        bus_read(2'd3, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL w1c_clear: got %h required 0", rd); end
    endtask

    task automatic test_irq();
        logic [31:0] rd;
        logic        exp;
        bus_write(2'd1, 32'h0004_0000);
        bus_read(2'd1, rd);
        n_checks++;
        if (rd !== (IrqOn ? 32'h0004_0000 : 32'h0)) begin
            n_fail++; $display("FAIL irq_en_read: got %h", rd);
        end
        sw[2] = 1'b1;
        for (int k = 1; k <= int'(Deb) + 4; k++) begin
            @(posedge clk); @(negedge clk);
            exp = IrqOn && (k >= int'(Deb) + 3);
            n_checks++;
            if (irq !== exp) begin n_fail++; $display("FAIL irq_ch2 k=%0d: got %b required %b", k, irq, exp); end
        end
        bus_write(2'd3, 32'h4);
        n_checks++;
        if (irq !== IrqOn) begin n_fail++; $display("FAIL irq_w1c_lag: got %b required %b", irq, IrqOn); end
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_cleared: got %b required 0", irq); end
        sw[1] = 1'b1;
        for (int k = 1; k <= int'(Deb) + 4; k++) begin
            @(posedge clk); @(negedge clk);
            n_checks++;
            if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_ch1 k=%0d: got %b required 0", k, irq); end
        end
        bus_read(2'd3, rd);
        n_checks++;
        if (rd !== 32'h2) begin n_fail++; $display("FAIL irq_ch1_status: got %h required 2", rd); end
        bus_write(2'd3, 32'h2);
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        bus_write(2'd1, 32'h0);
        bus_write(2'd0, 32'hFFFF);
        bus_read(2'd0, rd);
        n_checks++;
        if (led !== 16'hFFFF || rd !== 32'hFFFF) begin
            n_fail++; $display("FAIL pre_reset: got led=%h rdata=%h required ffff ffff", led, rd);
        end
        sw[5] = 1'b1;
        for (int k = 1; k <= 4; k++) begin @(posedge clk); @(negedge clk); end
        #1 rstn = 1'b0;
        #1;
        n_checks++;
        if (led !== 16'h0 || sw_db !== 16'h0 || bus.o_rdata !== 32'h0) begin
            n_fail++; $display("FAIL async_reset: got led=%h db=%h rdata=%h required 0",
                               led, sw_db, bus.o_rdata);
        end
        @(negedge clk); rstn = 1'b1;
        for (int k = 1; k <= int'(Deb) + 3; k++) begin
            @(posedge clk); @(negedge clk);
            n_checks++;
            if (sw_db[5] !== (k >= int'(Deb) + 2)) begin
                n_fail++; $display("FAIL post_reset_db k=%0d: got %b required %b", k, sw_db[5],
                                   k >= int'(Deb) + 2);
            end
        end
    endtask

    initial begin
        bus.i_wr_en = 1'b0; bus.i_rd_en = 1'b0; bus.i_addr = '0; bus.i_wdata = '0;
        test_reset();
        test_debounce_accept();
        test_bounce();
        test_leds();
        test_w1c_race();
        test_irq();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
